// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer on the reference clock: pulses PLL reset, filters lock with a timeout
// and retry, holds the core in reset until lock is stable, and re-sequences on lock loss.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE    = 16,
    parameter int unsigned LOCK_FILTER  = 64,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned HOLD_CYCLES  = 32,
    parameter int unsigned CNT_W        = 17
) (
    input  logic       refclk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       relock_req_i,
    output logic       pll_rst_o,
    output logic       sys_reset_o,
    output logic       ready_o,
    output logic       lock_lost_o,
    output logic [7:0] retry_cnt_o
);

    typedef enum logic [1:0] {StResetPll, StWaitLock, StHold, StRun} state_e;

    state_e             state_q, state_d;
    logic [1:0]         sync_q;
    logic               locked_s;
    // Shared phase counter: pulse, timeout and hold counts live in mutually exclusive states
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic [7:0]         retry_q, retry_d;
    logic               lock_lost_q, lock_lost_d;
    logic               pll_rst_q, sys_reset_q, ready_q;

    assign locked_s = sync_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        fcnt_d      = fcnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        if (relock_req_i) begin
            state_d = StResetPll;
            cnt_d   = '0;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                StResetPll: begin
                    if (cnt_q == CNT_W'(RST_PULSE - 1)) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                        fcnt_d  = '0;
                    end
                end
                StWaitLock: begin
                    fcnt_d = locked_s ? fcnt_q + CNT_W'(1) : '0;
                    // Lock acceptance takes precedence over a coincident timeout
                    if (locked_s && (fcnt_q == CNT_W'(LOCK_FILTER - 1))) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_d = StResetPll;
                        cnt_d   = '0;
                        if (retry_q != 8'hff) begin
                            retry_d = retry_q + 8'd1;
                        end
                    end
                end
                StHold: begin
                    if (!locked_s) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                        fcnt_d  = '0;
                    end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end
                end
                StRun: begin
                    cnt_d = cnt_q;
                    if (!locked_s) begin
                        state_d     = StResetPll;
                        cnt_d       = '0;
                        lock_lost_d = 1'b1;
                    end
                end
                default: begin
                    state_d = StResetPll;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            sync_q      <= '0;
            state_q     <= StResetPll;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], pll_locked_i};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fcnt_q      <= fcnt_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
            pll_rst_q   <= (state_d == StResetPll);
            sys_reset_q <= (state_d != StRun);
            ready_q     <= (state_d == StRun);
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign sys_reset_o = sys_reset_q;
    assign ready_o     = ready_q;
    assign lock_lost_o = lock_lost_q;
    assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: two parameterisations share one stimulus stream; a timestamp
// based reference model queues expected outputs and a negedge monitor checks them.
module tb_pll_lock_supervisor;

    localparam int A_RST = 16;
    localparam int A_LF  = 64;
    localparam int A_TO  = 1000;
    localparam int A_H   = 32;
    localparam int B_RST = 2;
    localparam int B_LF  = 3;
    localparam int B_TO  = 5;
    localparam int B_H   = 2;

    typedef enum int {PhRst, PhWait, PhHold, PhRun} ph_e;

    typedef struct {
        ph_e ph;
        int  t_enter;
        int  last_zero;
        int  retries;
        bit  lost;
        bit  d1;
        bit  d2;
    } mdl_t;

    typedef struct {
        bit       prst;
        bit       sysr;
        bit       rdy;
        bit       lost;
        bit [7:0] retry;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       relock = 1'b0;
    logic       locked = 1'b0;
    logic       prst0, sysr0, rdy0, lost0, prst1, sysr1, rdy1, lost1;
    logic [7:0] rc0, rc1;

    mdl_t m [2];
    exp_t q0 [$];
    exp_t q1 [$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .RST_PULSE(A_RST), .LOCK_FILTER(A_LF), .LOCK_TIMEOUT(A_TO), .HOLD_CYCLES(A_H), .CNT_W(17)
    ) u_dut_a (
        .refclk_i(clk), .rst_i(rst), .pll_locked_i(locked), .relock_req_i(relock),
        .pll_rst_o(prst0), .sys_reset_o(sysr0), .ready_o(rdy0), .lock_lost_o(lost0),
        .retry_cnt_o(rc0)
    );

    pll_lock_supervisor #(
        .RST_PULSE(B_RST), .LOCK_FILTER(B_LF), .LOCK_TIMEOUT(B_TO), .HOLD_CYCLES(B_H), .CNT_W(4)
    ) u_dut_b (
        .refclk_i(clk), .rst_i(rst), .pll_locked_i(locked), .relock_req_i(relock),
        .pll_rst_o(prst1), .sys_reset_o(sysr1), .ready_o(rdy1), .lock_lost_o(lost1),
        .retry_cnt_o(rc1)
    );

    function automatic int p_rst(int k); return (k == 0) ? A_RST : B_RST; endfunction
    function automatic int p_lf(int k);  return (k == 0) ? A_LF  : B_LF;  endfunction
    function automatic int p_to(int k);  return (k == 0) ? A_TO  : B_TO;  endfunction
    function automatic int p_h(int k);   return (k == 0) ? A_H   : B_H;   endfunction

    function automatic exp_t expect_of(int k);
        exp_t e;
        e.prst  = (m[k].ph == PhRst);
        e.sysr  = (m[k].ph != PhRun);
        e.rdy   = (m[k].ph == PhRun);
        e.lost  = m[k].lost;
        e.retry = 8'(m[k].retries);
        return e;
    endfunction

    task automatic enter(int k, ph_e p, int n);
        m[k].ph      = p;
        m[k].t_enter = n + 1;
    endtask

    // Applies cycle n's inputs; phase timing is derived from entry timestamps and lock streaks.
    task automatic advance(int k, bit r, bit rq, bit lk, int n);
        bit ls;
        int age;
        int streak;
        int base;
        ls = m[k].d2;
        if (r) begin
            enter(k, PhRst, n);
            m[k].last_zero = n;
            m[k].retries   = 0;
            m[k].lost      = 1'b0;
            m[k].d1        = 1'b0;
            m[k].d2        = 1'b0;
            return;
        end
        m[k].d2   = m[k].d1;
        m[k].d1   = lk;
        m[k].lost = 1'b0;
        age = n - m[k].t_enter;
        if (!ls) m[k].last_zero = n;
        if (rq) begin
            enter(k, PhRst, n);
        end else begin
            case (m[k].ph)
                PhRst: if (age == p_rst(k) - 1) enter(k, PhWait, n);
                PhWait: begin
                    base   = (m[k].t_enter - 1 > m[k].last_zero) ? m[k].t_enter - 1
                                                                 : m[k].last_zero;
                    streak = ls ? n - base : 0;
                    if (ls && streak == p_lf(k)) begin
                        enter(k, PhHold, n);
                    end else if (age == p_to(k) - 1) begin
                        enter(k, PhRst, n);
                        if (m[k].retries < 255) m[k].retries++;
                    end
                end
                PhHold: begin
                    if (!ls) enter(k, PhWait, n);
                    else if (age == p_h(k) - 1) enter(k, PhRun, n);
                end
                default: begin
                    if (!ls) begin
                        enter(k, PhRst, n);
                        m[k].lost = 1'b1;
                    end
                end
            endcase
        end
    endtask

    task automatic step(bit r, bit rq, bit lk);
        @(posedge clk);
        #1;
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
        rst    = r;
        relock = rq;
        locked = lk;
        advance(0, r, rq, lk, cyc);
        advance(1, r, rq, lk, cyc);
        cyc++;
    endtask

    task automatic steps(int cnt, bit lk);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, lk);
    endtask

    task automatic check_vec(int k, exp_t e, logic prst, logic sysr, logic rdy, logic lost,
                             logic [7:0] rc);
        bit bad;
        bad = 1'b0;
        vectors++;
        if (prst !== e.prst) begin
            $display("FAIL dut%0d pll_rst @%0t: got %b want %b", k, $time, prst, e.prst);
            bad = 1'b1;
        end
        if (sysr !== e.sysr) begin
            $display("FAIL dut%0d sys_reset @%0t: got %b want %b", k, $time, sysr, e.sysr);
            bad = 1'b1;
        end
        if (rdy !== e.rdy) begin
            $display("FAIL dut%0d ready @%0t: got %b want %b", k, $time, rdy, e.rdy);
            bad = 1'b1;
        end
        if (lost !== e.lost) begin
            $display("FAIL dut%0d lock_lost @%0t: got %b want %b", k, $time, lost, e.lost);
            bad = 1'b1;
        end
        if (rc !== e.retry) begin
            $display("FAIL dut%0d retry_cnt @%0t: got %0d want %0d", k, $time, rc, e.retry);
            bad = 1'b1;
        end
        if (bad) miscompares++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check_vec(0, e, prst0, sysr0, rdy0, lost0, rc0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check_vec(1, e, prst1, sysr1, rdy1, lost1, rc1);
        end
    end

    initial begin
        bit lk;
        bit hit;
        advance(0, 1'b1, 1'b0, 1'b0, -1);
        advance(1, 1'b1, 1'b0, 1'b0, -1);

        // Reset, then normal bring-up and a lock drop while running
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        steps(200, 1'b1);
        steps(5, 1'b0);
        steps(200, 1'b1);

        // relock_req while running
        step(1'b0, 1'b1, 1'b1);
        steps(150, 1'b1);

        // Single-cycle lock glitch inside WAIT_LOCK
        step(1'b0, 1'b1, 1'b1);
        steps(54, 1'b1);
        steps(1, 1'b0);
        steps(150, 1'b1);

        // Lock drop during HOLD
        step(1'b0, 1'b1, 1'b1);
        steps(89, 1'b1);
        steps(1, 1'b0);
        steps(200, 1'b1);

        // No lock: repeated timeouts, small instance saturates retry_cnt
        steps(2200, 1'b0);

        // relock_req in the very cycle the large instance times out
        hit = 1'b0;
        for (int i = 0; i < 2100 && !hit; i++) begin
            if (m[0].ph == PhWait && cyc - m[0].t_enter == A_TO - 1) begin
                step(1'b0, 1'b1, 1'b0);
                hit = 1'b1;
            end else begin
                step(1'b0, 1'b0, 1'b0);
            end
        end
        vectors++;
        if (!hit) begin
            $display("FAIL timeout_align: got no timeout cycle within 2100 cycles, want one");
            miscompares++;
        end
        steps(30, 1'b0);

        // rst asserted in the middle of WAIT_LOCK
        step(1'b0, 1'b1, 1'b1);
        steps(30, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        steps(200, 1'b1);

        // Randomized lock dwell, occasional relock_req and rst
        lk = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(399, 0) == 0) lk = ~lk;
            step(($urandom_range(7999, 0) == 0), ($urandom_range(2999, 0) == 0), lk);
        end

        repeat (3) @(posedge clk);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            $display("FAIL drain: got %0d/%0d pending, want 0", q0.size(), q1.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
